// File: rtl/partition_axis_bridge_if.sv
// partition_axis_bridge_if: stream channel carrying BYTES bytes per beat, with master/slave views
interface partition_axis_bridge_if #(
    parameter int BYTES = 1
);
    logic [8*BYTES-1:0] tdata;
    logic [BYTES-1:0]   tkeep;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/partition_axis_bridge.sv
// partition_axis_bridge: packs payload bytes LSB-first into words and unpacks result words into bytes
// Define PARTITION_BRIDGE_STATS_EN to build the rx/tx frame counters; otherwise they read 0.
module partition_axis_bridge #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    partition_axis_bridge_if.slave  s_byte,
    partition_axis_bridge_if.master m_word,
    partition_axis_bridge_if.slave  s_word,
    partition_axis_bridge_if.master m_byte,
    output logic                    status_drop,
    output logic [15:0]             rx_frame_count,
    output logic [15:0]             tx_frame_count
);
    localparam int DW = 8 * WORD_BYTES;
    localparam int KW = $clog2(WORD_BYTES);
    localparam logic [KW-1:0] K_LAST = KW'(WORD_BYTES - 1);

    logic [DW-1:0]         acc, acc_merged, out_data;
    logic [WORD_BYTES-1:0] acc_keep, close_keep, out_keep;
    logic [KW-1:0]         k;
    logic                  acc_full, acc_last, out_valid, out_last;
    logic                  byte_hs, close, drain, out_free;

    assign byte_hs    = s_byte.tvalid & s_byte.tready;
    assign close      = byte_hs & ((k == K_LAST) | s_byte.tlast);
    assign drain      = out_valid & m_word.tready;
    assign out_free   = !out_valid | drain;
    // acc only ever holds bytes below k, so OR-ing in the new byte keeps unused bytes zero
    assign acc_merged = acc | (DW'(s_byte.tdata) << (8 * k));
    assign close_keep = WORD_BYTES'((32'd1 << (32'(k) + 32'd1)) - 32'd1);

    assign s_byte.tready = !acc_full;
    assign m_word.tdata  = out_data;
    assign m_word.tkeep  = out_keep;
    assign m_word.tvalid = out_valid;
    assign m_word.tlast  = out_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            acc_keep  <= '0;
            acc_last  <= 1'b0;
            acc_full  <= 1'b0;
            k         <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (acc_full && out_free) begin
            out_data  <= acc;
            out_keep  <= acc_keep;
            out_last  <= acc_last;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_full  <= 1'b0;
        end else if (close && out_free) begin
            out_data  <= acc_merged;
            out_keep  <= close_keep;
            out_last  <= s_byte.tlast;
            out_valid <= 1'b1;
            acc       <= '0;
            k         <= '0;
        end else begin
            if (drain) out_valid <= 1'b0;
            if (close) begin
                acc      <= acc_merged;
                acc_keep <= close_keep;
                acc_last <= s_byte.tlast;
                acc_full <= 1'b1;
                k        <= '0;
            end else if (byte_hs) begin
                acc <= acc_merged;
                k   <= k + 1'b1;
            end
        end
    end

    typedef enum logic {IDLE, SEND} state_t;
    state_t                state;
    logic [DW-1:0]         w_data;
    logic [WORD_BYTES-1:0] w_keep, keep_sh;
    logic [KW-1:0]         idx;
    logic                  w_last, last_byte, word_hs, bout_hs;

    // bit 1 of the shifted keep is the next byte; it is 0 past the top byte as well
    assign keep_sh       = w_keep >> idx;
    assign last_byte     = !keep_sh[1];
    assign bout_hs       = m_byte.tvalid & m_byte.tready;
    assign s_word.tready = (state == IDLE) | (bout_hs & last_byte);
    assign word_hs       = s_word.tvalid & s_word.tready;
    assign m_byte.tvalid = state == SEND;
    assign m_byte.tdata  = w_data[8*idx +: 8];
    assign m_byte.tkeep  = 1'b1;
    assign m_byte.tlast  = last_byte & w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            w_data      <= '0;
            w_keep      <= '0;
            w_last      <= 1'b0;
            status_drop <= 1'b0;
        end else begin
            status_drop <= word_hs & ~|s_word.tkeep;
            if (word_hs && |s_word.tkeep) begin
                state  <= SEND;
                idx    <= '0;
                w_data <= s_word.tdata;
                w_keep <= s_word.tkeep;
                w_last <= s_word.tlast;
            end else if (bout_hs) begin
                if (last_byte) state <= IDLE;
                else idx <= idx + 1'b1;
            end
        end
    end

`ifdef PARTITION_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_frame_count <= '0;
            tx_frame_count <= '0;
        end else begin
            if (drain && out_last) rx_frame_count <= rx_frame_count + 16'd1;
            if (bout_hs && m_byte.tlast) tx_frame_count <= tx_frame_count + 16'd1;
        end
    end
`else
    assign rx_frame_count = '0;
    assign tx_frame_count = '0;
`endif
endmodule

// File: tb/tb_partition_axis_bridge.sv
// tb_partition_axis_bridge: directed + randomized bench with a queue-based reference model of both paths
module tb_partition_axis_bridge;
    localparam int WB = 4;
    typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
    typedef struct { logic [7:0] data; logic last; logic eow; } byte_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic status_drop;
    logic [15:0] rx_frame_count, tx_frame_count;
    int vectors = 0, miscompares = 0;
    int mw_mode = 0, mb_mode = 0;
    bit thru_chk = 0;
    int bytes_acc = 0, drops = 0, exp_drop = 0;
    logic [15:0] exp_rx = 0, exp_tx = 0;
    word_t exp_w[$];
    byte_t exp_b[$];
    logic [7:0] fbytes[$];
    word_t ew;
    byte_t eb;
    logic [36:0] held;
    bit hold_d = 0, close_d = 0;
    int wcnt = 0;

    partition_axis_bridge_if #(.BYTES(1))  s_byte();
    partition_axis_bridge_if #(.BYTES(WB)) m_word();
    partition_axis_bridge_if #(.BYTES(WB)) s_word();
    partition_axis_bridge_if #(.BYTES(1))  m_byte();

    partition_axis_bridge #(.WORD_BYTES(WB)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_byte(s_byte), .m_word(m_word), .s_word(s_word), .m_byte(m_byte),
        .status_drop(status_drop), .rx_frame_count(rx_frame_count), .tx_frame_count(tx_frame_count)
    );

    always #5 clk = ~clk;

    // mode 0: ready high, 1: ready low, 2: random ready each cycle
    always @(posedge clk) begin
        #1;
        m_word.tready = mw_mode == 0 ? 1'b1 : mw_mode == 1 ? 1'b0 : 1'($urandom_range(1));
        m_byte.tready = mb_mode == 0 ? 1'b1 : mb_mode == 1 ? 1'b0 : 1'($urandom_range(1));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit last, input bit gaps);
        int n, cnt;
        word_t e;
        n = fbytes.size();
        for (int w = 0; w * WB < n; w++) begin
            cnt = (n - w * WB < WB) ? n - w * WB : WB;
            if (cnt < WB && !last) continue;
            e.data = 0;
            for (int j = 0; j < cnt; j++) e.data |= 32'(fbytes[w*WB+j]) << (8 * j);
            e.keep = 4'((1 << cnt) - 1);
            e.last = last && (w * WB + cnt == n);
            exp_w.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            bit hs;
            hs = 0;
            if (gaps && $urandom_range(3) == 0) begin
                s_byte.tvalid = 1'b0;
                tick();
            end
            s_byte.tvalid = 1'b1;
            s_byte.tdata = fbytes[i];
            s_byte.tlast = last && i == n - 1;
            for (int t = 0; t < 200 && !hs; t++) begin
                @(negedge clk);
                hs = s_byte.tready;
                tick();
            end
            chk("byte_accept", hs, 1);
        end
        s_byte.tvalid = 1'b0;
        s_byte.tlast = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic [3:0] keep, input bit last);
        int n;
        bit hs;
        n = 0;
        hs = 0;
        while (n < WB && keep[n]) n++;
        if (n == 0) exp_drop++;
        for (int j = 0; j < n; j++) exp_b.push_back('{data[8*j +: 8], last && j == n - 1, j == n - 1});
        s_word.tvalid = 1'b1;
        s_word.tdata = data;
        s_word.tkeep = keep;
        s_word.tlast = last;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = s_word.tready;
            tick();
        end
        chk("word_accept", hs, 1);
        s_word.tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_w.size() != 0 || exp_b.size() != 0) && t < 2000) begin
            tick();
            t++;
        end
        chk("drain", exp_w.size() + exp_b.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_w.delete();
            wcnt = 0;
            hold_d = 0;
            close_d = 0;
            exp_rx = 0;
        end else begin
            chk("rx_frame_count", rx_frame_count, exp_rx);
            if (close_d) chk("word_latency", m_word.tvalid, 1);
            if (hold_d) chk("word_stable", {m_word.tlast, m_word.tkeep, m_word.tdata}, held);
            if (thru_chk) chk("byte_throughput", s_byte.tready, 1);
            if (m_word.tvalid && m_word.tready) begin
                chk("word_queue", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    ew = exp_w.pop_front();
                    chk("word_data", m_word.tdata, ew.data);
                    chk("word_keep", m_word.tkeep, ew.keep);
                    chk("word_last", m_word.tlast, ew.last);
`ifdef PARTITION_BRIDGE_STATS_EN
                    if (ew.last) exp_rx++;
`endif
                end
            end
            hold_d = m_word.tvalid && !m_word.tready;
            held = {m_word.tlast, m_word.tkeep, m_word.tdata};
            close_d = 0;
            if (s_byte.tvalid && s_byte.tready) begin
                close_d = wcnt == WB - 1 || s_byte.tlast;
                wcnt = close_d ? 0 : wcnt + 1;
                bytes_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_b.delete();
            exp_tx = 0;
        end else begin
            chk("tx_frame_count", tx_frame_count, exp_tx);
            chk("word_tready", s_word.tready, !m_byte.tvalid || (exp_b.size() > 0 && exp_b[0].eow && m_byte.tready));
            if (m_byte.tvalid) chk("byte_queue", exp_b.size() != 0, 1);
            if (m_byte.tvalid && m_byte.tready && exp_b.size() != 0) begin
                eb = exp_b.pop_front();
                chk("byte_data", m_byte.tdata, eb.data);
                chk("byte_last", m_byte.tlast, eb.last);
`ifdef PARTITION_BRIDGE_STATS_EN
                if (eb.last) exp_tx++;
`endif
            end
            if (status_drop) drops++;
        end
    end

    initial begin
        int b0, d0;
        s_byte.tvalid = 1'b0;
        s_byte.tdata = '0;
        s_byte.tlast = 1'b0;
        s_byte.tkeep = 1'b1;
        s_word.tvalid = 1'b0;
        s_word.tdata = '0;
        s_word.tkeep = '0;
        s_word.tlast = 1'b0;
        repeat (2) tick();
        chk("rst_m_word_tvalid", m_word.tvalid, 0);
        chk("rst_m_byte_tvalid", m_byte.tvalid, 0);
        chk("rst_status_drop", status_drop, 0);
        chk("rst_s_byte_tready", s_byte.tready, 1);
        chk("rst_s_word_tready", s_word.tready, 1);
        chk("rst_rx_count", rx_frame_count, 0);
        chk("rst_tx_count", tx_frame_count, 0);
        reset_n = 1'b1;
        repeat (2) tick();
        // T1/T2: full-rate packing, one byte per cycle, with a short final word
        thru_chk = 1;
        fbytes.delete();
        for (int i = 1; i <= 8; i++) fbytes.push_back(8'(i));
        send_frame(1, 0);
        fbytes.delete();
        for (int i = 0; i < 5; i++) fbytes.push_back(8'(8'hAA + 8'h11 * i));
        send_frame(1, 0);
        repeat (3) tick();
        thru_chk = 0;
        // T3: output stalled during a 12-byte stream
        mw_mode = 1;
        repeat (2) tick();
        fbytes.delete();
        for (int i = 0; i < 12; i++) fbytes.push_back(8'($urandom));
        b0 = bytes_acc;
        fork
            send_frame(1, 0);
            begin
                repeat (10) tick();
                chk("t3_bytes_accepted", bytes_acc - b0, 8);
                chk("t3_s_byte_tready", s_byte.tready, 0);
                mw_mode = 0;
            end
        join
        drain();
        // T4: partial word with toggling byte ready
        mb_mode = 2;
        send_word(32'h44332211, 4'h7, 1);
        drain();
        // T5: zero-keep word is dropped with a single pulse
        d0 = drops;
        send_word(32'h12345678, 4'h0, 1);
        repeat (4) tick();
        chk("t5_drop_pulses", drops - d0, 1);
        send_word($urandom, 4'b1011, 1);
        drain();
        // random traffic on both paths at once
        mw_mode = 2;
        fork
            for (int f = 0; f < 12; f++) begin
                int n;
                fbytes.delete();
                n = $urandom_range(1, 13);
                for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom));
                send_frame(1, 1);
            end
            for (int w = 0; w < 30; w++) begin
                logic [3:0] kp;
                kp = 4'((1 << $urandom_range(0, WB)) - 1);
                if ($urandom_range(7) == 0) kp = 4'($urandom);
                send_word($urandom, kp, 1'($urandom_range(1)));
            end
        join
        drain();
        // T6: reset mid-word on both paths
        mw_mode = 0;
        mb_mode = 1;
        repeat (2) tick();
        fbytes.delete();
        for (int i = 0; i < 2; i++) fbytes.push_back(8'($urandom));
        send_frame(0, 0);
        send_word($urandom, 4'hF, 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t6_m_word_tvalid", m_word.tvalid, 0);
        chk("t6_m_byte_tvalid", m_byte.tvalid, 0);
        chk("t6_s_byte_tready", s_byte.tready, 1);
        chk("t6_s_word_tready", s_word.tready, 1);
        chk("t6_status_drop", status_drop, 0);
        tick();
        reset_n = 1'b1;
        mb_mode = 0;
        tick();
        fbytes.delete();
        for (int i = 0; i < 3; i++) fbytes.push_back(8'($urandom));
        send_frame(1, 0);
        send_word($urandom, 4'h3, 1);
        drain();
`ifdef PARTITION_BRIDGE_STATS_EN
        fbytes.delete();
        fbytes.push_back(8'h5A);
        for (int i = 0; i < 65536; i++) send_frame(1, 0);
        drain();
`endif
        repeat (4) tick();
        chk("drop_total", drops, exp_drop);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
